// File: rtl/univ_shift_reg.sv
// Universal shift register: bidirectional serial shift, parallel load/read, and a
// bits-remaining counter with a one-cycle done pulse. Define UNIV_SHIFT_REG_ROTATE_EN to rotate.
module univ_shift_reg #(
   parameter int unsigned WIDTH = 8,
   localparam int unsigned CW = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             sin_r,
   input  logic             sin_l,
   input  logic [WIDTH-1:0] pin,
   output logic [WIDTH-1:0] q,
   output logic             sout_r,
   output logic             sout_l,
   output logic [CW-1:0]    cnt,
   output logic             empty,
   output logic             done
);

   typedef enum logic [1:0] {
      ModeHold  = 2'b00,
      ModeShr   = 2'b01,
      ModeShl   = 2'b10,
      ModeLoad  = 2'b11
   } mode_e;

   logic [WIDTH-1:0] data_q, data_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             done_q, done_d;
   logic             shr_in, shl_in;
   mode_e            mode_sel;

`ifdef UNIV_SHIFT_REG_ROTATE_EN
   // Serial inputs are kept as ports but the shift wraps the register onto itself.
   logic unused_sin;
   assign unused_sin = sin_r ^ sin_l;
   assign shr_in     = data_q[0];
   assign shl_in     = data_q[WIDTH-1];
`else
   assign shr_in = sin_r;
   assign shl_in = sin_l;
`endif

   assign mode_sel = mode_e'(mode);

   always_comb begin
      data_d = data_q;
      cnt_d  = cnt_q;
      done_d = 1'b0;
      if (en) begin
         unique case (mode_sel)
            ModeHold: begin
               data_d = data_q;
            end
            ModeShr: begin
               data_d = {shr_in, data_q[WIDTH-1:1]};
            end
            ModeShl: begin
               data_d = {data_q[WIDTH-2:0], shl_in};
            end
            ModeLoad: begin
               data_d = pin;
               cnt_d  = CW'(WIDTH);
            end
            default: begin
               data_d = data_q;
            end
         endcase
         // Every shift, in either direction, consumes one bit of the loaded word.
         if ((mode_sel == ModeShr) || (mode_sel == ModeShl)) begin
            if (cnt_q > CW'(1)) begin
               cnt_d = cnt_q - CW'(1);
            end else if (cnt_q == CW'(1)) begin
               cnt_d  = '0;
               done_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= '0;
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         data_q <= data_d;
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   assign q      = data_q;
   assign sout_r = data_q[0];
   assign sout_l = data_q[WIDTH-1];
   assign cnt    = cnt_q;
   assign empty  = (cnt_q == '0);
   assign done   = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=4): directed scenarios plus randomized
// traffic, all checked against an arithmetic reference model.
module tb_univ_shift_reg;

   localparam int unsigned W    = 4;
   localparam int unsigned CWT  = $clog2(W + 1);
   localparam int          MASK = (1 << W) - 1;

   logic           clk;
   logic           rst;
   logic           en;
   logic [1:0]     mode;
   logic           sin_r;
   logic           sin_l;
   logic [W-1:0]   pin;
   logic [W-1:0]   q;
   logic           sout_r;
   logic           sout_l;
   logic [CWT-1:0] cnt;
   logic           empty;
   logic           done;

   int n_checks = 0;
   int n_fails  = 0;

   // Reference model state
   int m_q    = 0;
   int m_cnt  = 0;
   int m_done = 0;

   univ_shift_reg #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .mode   (mode),
      .sin_r  (sin_r),
      .sin_l  (sin_l),
      .pin    (pin),
      .q      (q),
      .sout_r (sout_r),
      .sout_l (sout_l),
      .cnt    (cnt),
      .empty  (empty),
      .done   (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_update(input logic r, input logic e, input logic [1:0] m,
                               input logic sr, input logic sl, input logic [W-1:0] p);
      int in_bit;
      if (r) begin
         m_q = 0; m_cnt = 0; m_done = 0;
      end else begin
         m_done = 0;
         if (e) begin
            if (m == 2'b01 || m == 2'b10) begin
`ifdef UNIV_SHIFT_REG_ROTATE_EN
               in_bit = (m == 2'b01) ? (m_q & 1) : ((m_q >> (W - 1)) & 1);
`else
               in_bit = (m == 2'b01) ? int'(sr) : int'(sl);
`endif
               if (m == 2'b01) m_q = (m_q >> 1) | (in_bit << (W - 1));
               else            m_q = ((m_q << 1) | in_bit) & MASK;
               if (m_cnt > 0) begin
                  m_cnt = m_cnt - 1;
                  if (m_cnt == 0) m_done = 1;
               end
            end else if (m == 2'b11) begin
               m_q   = int'(p);
               m_cnt = W;
            end
         end
      end
   endtask

   task automatic compare_all();
      check("q",      32'(q),      32'(m_q));
      check("cnt",    32'(cnt),    32'(m_cnt));
      check("empty",  32'(empty),  32'(m_cnt == 0));
      check("done",   32'(done),   32'(m_done));
      check("sout_r", 32'(sout_r), 32'(m_q & 1));
      check("sout_l", 32'(sout_l), 32'((m_q >> (W - 1)) & 1));
   endtask

   task automatic step(input logic r, input logic e, input logic [1:0] m,
                       input logic sr, input logic sl, input logic [W-1:0] p);
      rst = r; en = e; mode = m; sin_r = sr; sin_l = sl; pin = p;
      @(posedge clk);
      model_update(r, e, m, sr, sl, p);
      #1;
      compare_all();
   endtask

   initial begin
      logic [W-1:0] exp_q [4];
      logic         exp_so [4];
      logic         bits [4];

      rst = 1'b1; en = 1'b1; mode = 2'b11; sin_r = 1'b0; sin_l = 1'b0; pin = '1;

      // Reset dominates a pending load
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 4'hF);
         check("rst_q", 32'(q), 32'h0);
         check("rst_empty", 32'(empty), 32'h1);
      end

`ifndef UNIV_SHIFT_REG_ROTATE_EN
      // Right serialise
      exp_q  = '{4'b0101, 4'b0010, 4'b0001, 4'b0000};
      exp_so = '{1'b1, 1'b0, 1'b1, 1'b0};
      step(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 4'b1011);
      check("ser_first_bit", 32'(sout_r), 32'h1);
      check("ser_cnt_load", 32'(cnt), 32'd4);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 4'h0);
         check("ser_q", 32'(q), 32'(exp_q[i]));
         check("ser_sout", 32'(sout_r), 32'(exp_so[i]));
         check("ser_cnt", 32'(cnt), 32'(3 - i));
         check("ser_done", 32'(done), 32'(i == 3));
      end
      step(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 4'h0);
      check("ser_done_once", 32'(done), 32'h0);

      // Left deserialise from an empty register
      bits = '{1'b1, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, 2'b10, 1'b0, bits[i], 4'h0);
         check("deser_done", 32'(done), 32'h0);
         check("deser_cnt", 32'(cnt), 32'h0);
      end
      check("deser_q", 32'(q), 32'b1001);
`else
      // Rotate right ignores sin_r
      exp_q = '{4'b0100, 4'b0010, 4'b0001, 4'b1000};
      step(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 4'b1000);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 4'h0);
         check("rot_q", 32'(q), 32'(exp_q[i]));
         check("rot_done", 32'(done), 32'(i == 3));
      end
`endif

      // Hold via en=0, then abort with a fresh load
      step(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 4'b1100);
      step(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 4'h0);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 2'(i + 1), 1'b1, 1'b1, 4'hA);
         check("hold_q", 32'(q), 32'b0110);
         check("hold_cnt", 32'(cnt), 32'd3);
      end
      step(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 4'b0011);
      check("abort_cnt", 32'(cnt), 32'd4);
      check("abort_done", 32'(done), 32'h0);

      // Reset mid-word
      step(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 4'b1111);
      step(1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 4'h0);
      step(1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 4'h0);
      step(1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 4'h0);
      check("midrst_q", 32'(q), 32'h0);
      check("midrst_cnt", 32'(cnt), 32'h0);
      check("midrst_done", 32'(done), 32'h0);

      // Randomized traffic, loads frequent enough to exercise done pulses
      for (int i = 0; i < 2000; i++) begin
         step(($urandom_range(0, 99) < 2),
              ($urandom_range(0, 9) < 8),
              2'($urandom_range(0, 3)),
              1'($urandom), 1'($urandom), W'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
      $finish;
   end

endmodule
